// File: rtl/tlb_write_ctrl_if.sv
// TLB entry type and the EX/MEM <-> tlb_write_ctrl request/response bundle.
package tlb_write_ctrl_pkg;
    typedef struct packed {
        logic        e;
        logic [9:0]  asid;
        logic        g;
        logic [5:0]  ps;
        logic [18:0] vppn;
        logic        v0;
        logic        d0;
        logic [1:0]  mat0;
        logic [1:0]  plv0;
        logic [19:0] ppn0;
        logic        v1;
        logic        d1;
        logic [1:0]  mat1;
        logic [1:0]  plv1;
        logic [19:0] ppn1;
    } tlb_entry_t;
endpackage

interface tlb_write_ctrl_if #(
    parameter int unsigned IDX_W = 4
);
    import tlb_write_ctrl_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [IDX_W-1:0] req_idx;
    tlb_entry_t       req_entry;
    logic [4:0]       inv_op;
    logic [9:0]       inv_asid;
    logic [31:0]      inv_va;
    tlb_entry_t       rd_entry;
    logic [IDX_W-1:0] fill_idx;
    logic             op_done;
    logic             inv_err;

    modport master (
        output req_valid, req_op, req_idx, req_entry, inv_op, inv_asid, inv_va,
        input  req_ready, rd_entry, fill_idx, op_done, inv_err
    );

    modport slave (
        input  req_valid, req_op, req_idx, req_entry, inv_op, inv_asid, inv_va,
        output req_ready, rd_entry, fill_idx, op_done, inv_err
    );
endinterface

// File: rtl/tlb_write_ctrl.sv
// TLB entry array with TLBWR/TLBFILL/TLBRD and a one-entry-per-cycle INVTLB sweep.
// Define TLB_FILL_LFSR_EN to pick TLBFILL slots from a free-running LFSR instead of round-robin.
module tlb_write_ctrl
    import tlb_write_ctrl_pkg::*;
#(
    parameter int unsigned ENTRY_NUM = 16,
    parameter int unsigned IDX_W     = $clog2(ENTRY_NUM)
) (
    input  logic                            clk,
    input  logic                            rst,
    tlb_write_ctrl_if.slave                 bus,
    output tlb_entry_t [ENTRY_NUM-1:0]      entrys
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_TLBWR   = 2'd0,
        OP_TLBFILL = 2'd1,
        OP_TLBRD   = 2'd2,
        OP_INVTLB  = 2'd3
    } req_op_e;

    state_e                      state_q,     state_d;
    tlb_entry_t [ENTRY_NUM-1:0]  entrys_q,    entrys_d;
    logic [IDX_W-1:0]            sweep_idx_q, sweep_idx_d;
    logic [4:0]                  inv_op_q,    inv_op_d;
    logic [9:0]                  inv_asid_q,  inv_asid_d;
    logic [31:0]                 inv_va_q,    inv_va_d;
    logic                        inv_err_q,   inv_err_d;
    tlb_entry_t                  rd_entry_q,  rd_entry_d;
    logic [IDX_W-1:0]            fill_idx_q,  fill_idx_d;
    logic [IDX_W-1:0]            fill_ptr;
    logic                        accept;

`ifdef TLB_FILL_LFSR_EN
    logic [15:0]                 ptr_q, ptr_d;
    assign fill_ptr = ptr_q[IDX_W-1:0];
`else
    logic [IDX_W-1:0]            ptr_q, ptr_d;
    assign fill_ptr = ptr_q;
`endif

    function automatic logic inv_match(
        input tlb_entry_t  ent,
        input logic [4:0]  op,
        input logic [9:0]  asid,
        input logic [31:0] va
    );
        logic va_hit;
        logic asid_hit;
        logic hit;
        va_hit   = (ent.ps == 6'd21) ? (ent.vppn[18:9] == va[31:22])
                                     : (ent.vppn == va[31:13]);
        asid_hit = (ent.asid == asid);
        case (op)
            5'd0, 5'd1: hit = 1'b1;
            5'd2:       hit = ent.g;
            5'd3:       hit = !ent.g;
            5'd4:       hit = !ent.g && asid_hit;
            5'd5:       hit = !ent.g && asid_hit && va_hit;
            5'd6:       hit = (ent.g || asid_hit) && va_hit;
            default:    hit = 1'b0;
        endcase
        return hit;
    endfunction

    // DONE is the completion cycle; the block is already free to take the next request there.
    assign bus.req_ready = (state_q != ST_SWEEP);
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.op_done   = (state_q == ST_DONE);
    assign bus.inv_err   = (state_q == ST_DONE) && inv_err_q;
    assign bus.rd_entry  = rd_entry_q;
    assign bus.fill_idx  = fill_idx_q;
    assign entrys        = entrys_q;

    always_comb begin
        state_d     = state_q;
        entrys_d    = entrys_q;
        sweep_idx_d = sweep_idx_q;
        inv_op_d    = inv_op_q;
        inv_asid_d  = inv_asid_q;
        inv_va_d    = inv_va_q;
        inv_err_d   = inv_err_q;
        rd_entry_d  = rd_entry_q;
        fill_idx_d  = fill_idx_q;
`ifdef TLB_FILL_LFSR_EN
        ptr_d       = {ptr_q[14:0], ptr_q[15] ^ ptr_q[13] ^ ptr_q[12] ^ ptr_q[10]};
`else
        ptr_d       = ptr_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    inv_err_d = 1'b0;
                    state_d   = ST_DONE;
                    case (bus.req_op)
                        OP_TLBWR: begin
                            entrys_d[bus.req_idx] = bus.req_entry;
                        end
                        OP_TLBFILL: begin
                            entrys_d[fill_ptr] = bus.req_entry;
                            fill_idx_d         = fill_ptr;
`ifndef TLB_FILL_LFSR_EN
                            ptr_d              = ptr_q + IDX_W'(1);
`endif
                        end
                        OP_TLBRD: begin
                            rd_entry_d = entrys_q[bus.req_idx];
                        end
                        default: begin
                            if (bus.inv_op > 5'd6) begin
                                inv_err_d = 1'b1;
                            end else begin
                                inv_op_d    = bus.inv_op;
                                inv_asid_d  = bus.inv_asid;
                                inv_va_d    = bus.inv_va;
                                sweep_idx_d = '0;
                                state_d     = ST_SWEEP;
                            end
                        end
                    endcase
                end
            end
            ST_SWEEP: begin
                if (inv_match(entrys_q[sweep_idx_q], inv_op_q, inv_asid_q, inv_va_q)) begin
                    entrys_d[sweep_idx_q].e = 1'b0;
                end
                if (sweep_idx_q == IDX_W'(ENTRY_NUM - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    sweep_idx_d = sweep_idx_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            entrys_q    <= '0;
            sweep_idx_q <= '0;
            inv_op_q    <= '0;
            inv_asid_q  <= '0;
            inv_va_q    <= '0;
            inv_err_q   <= 1'b0;
            rd_entry_q  <= '0;
            fill_idx_q  <= '0;
`ifdef TLB_FILL_LFSR_EN
            ptr_q       <= 16'h0001;
`else
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            entrys_q    <= entrys_d;
            sweep_idx_q <= sweep_idx_d;
            inv_op_q    <= inv_op_d;
            inv_asid_q  <= inv_asid_d;
            inv_va_q    <= inv_va_d;
            inv_err_q   <= inv_err_d;
            rd_entry_q  <= rd_entry_d;
            fill_idx_q  <= fill_idx_d;
            ptr_q       <= ptr_d;
        end
    end

endmodule
